// File: rtl/lsu_pkg.sv
// Shared definitions for the MEM-stage load/store controller.
// Holds the load/store type encodings, the FSM state enum and byte-enable constants.
package lsu_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned BE_W   = 4;

  typedef enum logic [2:0] {
    LT_LB  = 3'b000,
    LT_LBU = 3'b001,
    LT_LH  = 3'b010,
    LT_LHU = 3'b011,
    LT_LW  = 3'b100
  } load_type_e;

  typedef enum logic [1:0] {
    ST_SB = 2'b00,
    ST_SH = 2'b01,
    ST_SW = 2'b10
  } store_type_e;

  typedef enum logic [1:0] {
    S_IDLE     = 2'b00,
    S_WAIT_ACK = 2'b01,
    S_DONE     = 2'b10
  } lsu_state_e;

  localparam logic [BE_W-1:0] BE_BYTE = 4'b0001;
  localparam logic [BE_W-1:0] BE_HALF = 4'b0011;
  localparam logic [BE_W-1:0] BE_WORD = 4'b1111;

endpackage

// File: rtl/lsu_align.sv
// Lane logic for the load/store controller (purely combinational).
// Command side : i_is_load, i_load_type, i_store_type, i_addr_lo, i_wdata
//                -> o_be_c, o_wdata_c, o_misaligned_c
// Response side: i_rd_type, i_rd_addr_lo, i_rdata -> o_rdata_c (extended load data)
module lsu_align
  import lsu_pkg::*;
(
  input  logic              i_is_load,
  input  logic [2:0]        i_load_type,
  input  logic [1:0]        i_store_type,
  input  logic [1:0]        i_addr_lo,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [2:0]        i_rd_type,
  input  logic [1:0]        i_rd_addr_lo,
  input  logic [DATA_W-1:0] i_rdata,
  output logic [BE_W-1:0]   o_be_c,
  output logic [DATA_W-1:0] o_wdata_c,
  output logic              o_misaligned_c,
  output logic [DATA_W-1:0] o_rdata_c
);

  load_type_e  w_lt;
  store_type_e w_st;
  load_type_e  w_rd_lt;
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Byte enables, replicated write data and misalignment for the incoming access
  always_comb begin
    w_lt           = load_type_e'(i_load_type);
    w_st           = store_type_e'(i_store_type);
    o_be_c         = BE_WORD;
    o_wdata_c      = i_wdata;
    o_misaligned_c = 1'b0;
    if (i_is_load) begin
      case (w_lt)
        LT_LB, LT_LBU: o_misaligned_c = 1'b0;
        LT_LH, LT_LHU: o_misaligned_c = i_addr_lo[0];
        default:       o_misaligned_c = |i_addr_lo;
      endcase
    end else begin
      case (w_st)
        ST_SB: begin
          o_be_c    = BE_BYTE << i_addr_lo;
          o_wdata_c = {4{i_wdata[7:0]}};
        end
        ST_SH: begin
          o_be_c         = BE_HALF << {i_addr_lo[1], 1'b0};
          o_wdata_c      = {2{i_wdata[15:0]}};
          o_misaligned_c = i_addr_lo[0];
        end
        default: begin
          o_be_c         = BE_WORD;
          o_wdata_c      = i_wdata;
          o_misaligned_c = |i_addr_lo;
        end
      endcase
    end
  end

  // Lane select and sign/zero extension of the returned word
  always_comb begin
    w_rd_lt   = load_type_e'(i_rd_type);
    w_byte    = i_rdata[{i_rd_addr_lo, 3'b000} +: 8];
    w_half    = i_rdata[{i_rd_addr_lo[1], 4'b0000} +: 16];
    o_rdata_c = i_rdata;
    case (w_rd_lt)
      LT_LB:   o_rdata_c = {{24{w_byte[7]}}, w_byte};
      LT_LBU:  o_rdata_c = {24'h000000, w_byte};
      LT_LH:   o_rdata_c = {{16{w_half[15]}}, w_half};
      LT_LHU:  o_rdata_c = {16'h0000, w_half};
      default: o_rdata_c = i_rdata;
    endcase
  end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// MEM-stage memory access controller: single outstanding req/ack access,
// pipeline stall until completion, extended load data, misalign and timeout flags.
// Ports: clk_i/rst_ni; req_valid_i, is_load_i, is_store_i, load_type_i, store_type_i,
//        addr_i, wdata_i (decoded request); mem_req_o, mem_we_o, mem_addr_o, mem_be_o,
//        mem_wdata_o, mem_ack_i, mem_rdata_i (memory port); stall_o, done_o, rdata_o,
//        misaligned_o, err_o (pipeline side).
module lsu_mem_ctrl
  import lsu_pkg::*;
#(
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              req_valid_i,
  input  logic              is_load_i,
  input  logic              is_store_i,
  input  logic [2:0]        load_type_i,
  input  logic [1:0]        store_type_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [BE_W-1:0]   mem_be_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic              mem_ack_i,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              stall_o,
  output logic              done_o,
  output logic [DATA_W-1:0] rdata_o,
  output logic              misaligned_o,
  output logic              err_o
);

  localparam int unsigned      CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  lsu_state_e        r_state,     w_state_nxt;
  logic [CNT_W-1:0]  r_cnt,       w_cnt_nxt;
  logic              r_mem_req,   w_req_nxt;
  logic              r_mem_we,    w_we_nxt;
  logic [ADDR_W-1:0] r_mem_addr,  w_addr_nxt;
  logic [BE_W-1:0]   r_mem_be,    w_be_nxt;
  logic [DATA_W-1:0] r_mem_wdata, w_wdata_nxt;
  logic [DATA_W-1:0] r_rdata,     w_rdata_nxt;
  logic              r_err,       w_err_nxt;
  logic [2:0]        r_rd_type,   w_rd_type_nxt;
  logic [1:0]        r_addr_lo,   w_addr_lo_nxt;

  logic              w_access;
  logic              w_stall_c;
  logic              w_done_c;
  logic              w_misaligned_c;
  logic [BE_W-1:0]   w_be_c;
  logic [DATA_W-1:0] w_wdata_c;
  logic              w_mis_c;
  logic [DATA_W-1:0] w_ext_rdata_c;

  assign w_access = req_valid_i & (is_load_i | is_store_i);

  lsu_align u_align (
    .i_is_load      (is_load_i),
    .i_load_type    (load_type_i),
    .i_store_type   (store_type_i),
    .i_addr_lo      (addr_i[1:0]),
    .i_wdata        (wdata_i),
    .i_rd_type      (r_rd_type),
    .i_rd_addr_lo   (r_addr_lo),
    .i_rdata        (mem_rdata_i),
    .o_be_c         (w_be_c),
    .o_wdata_c      (w_wdata_c),
    .o_misaligned_c (w_mis_c),
    .o_rdata_c      (w_ext_rdata_c)
  );

  // State and output registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_be    <= '0;
      r_mem_wdata <= '0;
      r_rdata     <= '0;
      r_err       <= 1'b0;
      r_rd_type   <= '0;
      r_addr_lo   <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_mem_req   <= w_req_nxt;
      r_mem_we    <= w_we_nxt;
      r_mem_addr  <= w_addr_nxt;
      r_mem_be    <= w_be_nxt;
      r_mem_wdata <= w_wdata_nxt;
      r_rdata     <= w_rdata_nxt;
      r_err       <= w_err_nxt;
      r_rd_type   <= w_rd_type_nxt;
      r_addr_lo   <= w_addr_lo_nxt;
    end
  end

  // Next-state logic; stall/done/misaligned are decoded combinationally
  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_req_nxt      = r_mem_req;
    w_we_nxt       = r_mem_we;
    w_addr_nxt     = r_mem_addr;
    w_be_nxt       = r_mem_be;
    w_wdata_nxt    = r_mem_wdata;
    w_rdata_nxt    = r_rdata;
    w_err_nxt      = r_err;
    w_rd_type_nxt  = r_rd_type;
    w_addr_lo_nxt  = r_addr_lo;
    w_stall_c      = 1'b0;
    w_done_c       = 1'b0;
    w_misaligned_c = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_access) begin
          if (w_mis_c) begin
            w_misaligned_c = 1'b1;
          end else begin
            w_stall_c     = 1'b1;
            w_req_nxt     = 1'b1;
            w_we_nxt      = ~is_load_i;
            w_addr_nxt    = {addr_i[ADDR_W-1:2], 2'b00};
            w_be_nxt      = w_be_c;
            w_wdata_nxt   = w_wdata_c;
            w_rd_type_nxt = load_type_i;
            w_addr_lo_nxt = addr_i[1:0];
            w_cnt_nxt     = '0;
            w_state_nxt   = S_WAIT_ACK;
          end
        end
      end
      S_WAIT_ACK: begin
        w_stall_c = 1'b1;
        // An ack arriving on the final allowed cycle still completes normally
        if (mem_ack_i) begin
          w_req_nxt   = 1'b0;
          w_err_nxt   = 1'b0;
          if (!r_mem_we) begin
            w_rdata_nxt = w_ext_rdata_c;
          end
          w_state_nxt = S_DONE;
        end else if (r_cnt == CNT_LAST) begin
          w_req_nxt   = 1'b0;
          w_rdata_nxt = '0;
          w_err_nxt   = 1'b1;
          w_state_nxt = S_DONE;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      S_DONE: begin
        w_done_c    = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign mem_req_o    = r_mem_req;
  assign mem_we_o     = r_mem_we;
  assign mem_addr_o   = r_mem_addr;
  assign mem_be_o     = r_mem_be;
  assign mem_wdata_o  = r_mem_wdata;
  assign rdata_o      = r_rdata;
  assign err_o        = r_err;
  assign stall_o      = w_stall_c;
  assign done_o       = w_done_c;
  assign misaligned_o = w_misaligned_c;

endmodule
